// File: rtl/apb_regspace_bridge_pkg.sv
// ---------------------------------------------------------------------------
// regspace_bridge_pkg : shared types/constants for the APB regspace bridge
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regspace_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Width able to hold TIMEOUT_CYC; never narrower than one bit.
  function automatic int to_cnt_w(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regspace_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_bus_if / regbank_req_if : APB3 bus and register-bank request bundles
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_bus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

interface regbank_req_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rreq_addr;
  logic              rreq_vld;
  logic              rreq_rdy;
  logic [DATA_W-1:0] rack_data;
  logic              rack_vld;
  logic              rack_rdy;
  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              wreq_vld;
  logic              wreq_rdy;

  modport master (
    output rreq_addr, rreq_vld, rack_rdy, wreq_addr, wreq_data, wreq_vld,
    input  rreq_rdy, rack_data, rack_vld, wreq_rdy
  );

  modport slave (
    input  rreq_addr, rreq_vld, rack_rdy, wreq_addr, wreq_data, wreq_vld,
    output rreq_rdy, rack_data, rack_vld, wreq_rdy
  );
endinterface

`default_nettype wire

// File: rtl/apb_regspace_bridge.sv
// ---------------------------------------------------------------------------
// apb_regspace_bridge : APB3 slave to register-bank request bridge with timeout
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_regspace_bridge
  import regspace_bridge_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  apb_bus_if.slave      apb,
  regbank_req_if.master bank,
  output logic          busy
);

  localparam int              CNT_W   = to_cnt_w(TIMEOUT_CYC);
  localparam bit              TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] prdata_q;
  logic              wr_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic setup;
  logic misaligned;
  logic rd_done;
  logic wr_done;
  logic xfer_done;
  logic to_hit;

  // rreq_rdy only mirrors the rack handshake; completion is judged on rack_vld.
  logic unused_rreq_rdy;
  assign unused_rreq_rdy = bank.rreq_rdy;

  assign setup      = apb.psel && !apb.penable;
  assign misaligned = (apb.paddr[1:0] & ALIGN_MASK) != 2'b00;
  assign rd_done    = (state_q == RD) && bank.rack_vld;
  assign wr_done    = (state_q == WR) && bank.wreq_rdy;
  assign xfer_done  = rd_done || wr_done;
  assign to_hit     = TO_EN && ((state_q == RD) || (state_q == WR))
                      && !xfer_done && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (misaligned)      state_d = DONE;
          else if (apb.pwrite) state_d = WR;
          else                 state_d = RD;
        end
      end
      RD, WR: begin
        if (xfer_done || to_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdat_q   <= '0;
      prdata_q <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == IDLE) begin
      if (setup) begin
        addr_q   <= apb.paddr;
        wdat_q   <= apb.pwdata;
        wr_q     <= apb.pwrite;
        err_q    <= misaligned;
        prdata_q <= '0;
        cnt_q    <= '0;
      end
    end else if ((state_q == RD) || (state_q == WR)) begin
      if (xfer_done) begin
        err_q <= 1'b0;
        if (rd_done) prdata_q <= bank.rack_data;
      end else if (to_hit) begin
        err_q    <= 1'b1;
        prdata_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // All outputs decode registered state only; nothing flows through from APB.
  assign apb.pready     = (state_q == DONE);
  assign apb.pslverr    = (state_q == DONE) && err_q;
  assign apb.prdata     = ((state_q == DONE) && !wr_q && !err_q) ? prdata_q : '0;
  assign bank.rreq_vld  = (state_q == RD);
  assign bank.rack_rdy  = (state_q == RD);
  assign bank.rreq_addr = addr_q;
  assign bank.wreq_vld  = (state_q == WR);
  assign bank.wreq_addr = addr_q;
  assign bank.wreq_data = wdat_q;
  assign busy           = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_apb_regspace_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_regspace_bridge : scoreboard bench for apb_regspace_bridge
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_regspace_bridge;

  logic clk;
  logic rst_n;
  logic busy;

  apb_bus_if     #(.ADDR_W(16), .DATA_W(32)) apb ();
  regbank_req_if #(.ADDR_W(16), .DATA_W(32)) bank ();

  apb_regspace_bridge #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .apb  (apb.slave),
    .bank (bank.master),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          nr;
    int          nw;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Bank model: responds after a programmable number of request cycles (-1 = never)
  int          rd_lat = 0;
  int          wr_lat = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] rdata_v = '0;
  logic [15:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  assign bank.rack_vld  = bank.rreq_vld && (rd_cnt == rd_lat);
  assign bank.rreq_rdy  = bank.rack_vld;
  assign bank.rack_data = rdata_v;
  assign bank.wreq_rdy  = bank.wreq_vld && (wr_cnt == wr_lat);

  always @(posedge clk) begin
    rd_cnt <= bank.rreq_vld ? rd_cnt + 1 : 0;
    wr_cnt <= bank.wreq_vld ? wr_cnt + 1 : 0;
    if (bank.wreq_vld && bank.wreq_rdy) begin
      last_wa <= bank.wreq_addr;
      last_wd <= bank.wreq_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: counts request-valid cycles and scores each completed transfer
  int n_r = 0;
  int n_w = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      n_r = 0;
      n_w = 0;
    end else begin
      if (bank.rreq_vld) n_r++;
      if (bank.wreq_vld) n_w++;
      if (apb.pready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pready: got pready with empty scoreboard, expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pslverr",   {31'd0, apb.pslverr}, {31'd0, e.err});
          chk("prdata",    apb.prdata, e.data);
          chk("rreq_cycles", n_r, e.nr);
          chk("wreq_cycles", n_w, e.nw);
        end
        n_r = 0;
        n_w = 0;
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          output int cyc);
    int guard;
    @(posedge clk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = a;
    apb.pwdata  = d;
    cyc = 1;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    cyc = 2;
    guard = 0;
    @(negedge clk);
    while (!apb.pready && guard < 100) begin
      @(posedge clk); #1;
      cyc++;
      guard++;
      @(negedge clk);
    end
    if (!apb.pready) begin
      vectors++;
      miscompares++;
      $display("FAIL pready_timeout: got no pready after %0d cycles, expected pready", cyc);
    end
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic push(input logic err, input logic [31:0] data, input int nr, input int nw);
    exp_t e;
    e.err = err; e.data = data; e.nr = nr; e.nw = nw;
    sb.push_back(e);
  endtask

  initial begin
    int cyc;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'd0, busy},          32'd0);
    chk("rst_pready",  {31'd0, apb.pready},    32'd0);
    chk("rst_rreq_vld", {31'd0, bank.rreq_vld}, 32'd0);
    chk("rst_wreq_vld", {31'd0, bank.wreq_vld}, 32'd0);
    chk("rst_prdata",  apb.prdata,             32'd0);
    rst_n = 1'b1;

    // Zero-wait read
    rd_lat = 0; rdata_v = 32'hA5A5_0003;
    push(1'b0, 32'hA5A5_0003, 1, 0);
    apb_xfer(1'b0, 16'h0020, 32'h0, cyc);
    chk("rd20_latency", cyc, 3);

    // Zero-wait write
    wr_lat = 0;
    push(1'b0, 32'h0, 0, 1);
    apb_xfer(1'b1, 16'h0060, 32'h0000_7802, cyc);
    chk("wr60_latency", cyc, 3);
    chk("wr60_addr", {16'd0, last_wa}, 32'h0000_0060);
    chk("wr60_data", last_wd, 32'h0000_7802);

    // Unmapped read times out
    rd_lat = -1; rdata_v = 32'hDEAD_BEEF;
    push(1'b1, 32'h0, 16, 0);
    apb_xfer(1'b0, 16'h0044, 32'h0, cyc);
    chk("rd44_timeout_latency", cyc, 18);

    // Normal read right after the timeout, two wait cycles
    rd_lat = 2; rdata_v = 32'h1234_5678;
    push(1'b0, 32'h1234_5678, 3, 0);
    apb_xfer(1'b0, 16'h0024, 32'h0, cyc);
    chk("rd24_latency", cyc, 5);

    // Misaligned write never reaches the bank
    wr_lat = 0;
    push(1'b1, 32'h0, 0, 0);
    apb_xfer(1'b1, 16'h0022, 32'hFFFF_FFFF, cyc);
    chk("wr22_misaligned_latency", cyc, 2);

    // Response lands exactly in the timeout cycle
    rd_lat = 15; rdata_v = 32'hCAFE_0001;
    push(1'b0, 32'hCAFE_0001, 16, 0);
    apb_xfer(1'b0, 16'h0030, 32'h0, cyc);
    chk("rd30_edge_latency", cyc, 18);

    // Write with three wait cycles
    wr_lat = 3;
    push(1'b0, 32'h0, 0, 4);
    apb_xfer(1'b1, 16'h0064, 32'h0BAD_F00D, cyc);
    chk("wr64_latency", cyc, 6);
    chk("wr64_data", last_wd, 32'h0BAD_F00D);

    // Misaligned read
    push(1'b1, 32'h0, 0, 0);
    apb_xfer(1'b0, 16'h0001, 32'h0, cyc);
    chk("rd01_misaligned_latency", cyc, 2);

    // Reset while a write is stalled in WR
    wr_lat = -1;
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 16'h0068; apb.pwdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    chk("wr68_stalled_vld", {31'd0, bank.wreq_vld}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wreq_vld", {31'd0, bank.wreq_vld}, 32'd0);
    chk("rst_mid_busy",     {31'd0, busy},          32'd0);
    chk("rst_mid_pready",   {31'd0, apb.pready},    32'd0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rd_lat = 0; rdata_v = 32'h0F0F_0F0F;
    push(1'b0, 32'h0F0F_0F0F, 1, 0);
    apb_xfer(1'b0, 16'h0020, 32'h0, cyc);
    chk("rd20_after_rst_latency", cyc, 3);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
